// File: rtl/slot_dispenser.sv
// Three-slot transmit dispenser: latches a bundle of up to three slots in one load
// cycle and emits the valid ones in ascending index order on a put/take handshake.
module slot_dispenser #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             in0_valid,
  input  logic             in1_valid,
  input  logic             in2_valid,
  input  logic             take,
  output logic [WIDTH-1:0] value_out,
  output logic             put_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StSend, StFin} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data0_q, data0_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic [WIDTH-1:0] data2_q, data2_d;
  logic [2:0]       valid_q, valid_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             put_q, put_d;
  logic [2:0]       in_valid;

  // Data of the lowest-index slot whose flag is set in m.
  function automatic logic [WIDTH-1:0] pick_first(input logic [2:0] m,
                                                  input logic [WIDTH-1:0] a0,
                                                  input logic [WIDTH-1:0] a1,
                                                  input logic [WIDTH-1:0] a2);
    if (m[0])      return a0;
    else if (m[1]) return a1;
    else if (m[2]) return a2;
    else           return '0;
  endfunction

  assign in_valid = {in2_valid, in1_valid, in0_valid};

  always_comb begin
    state_d = state_q;
    data0_d = data0_q;
    data1_d = data1_q;
    data2_d = data2_q;
    valid_d = valid_q;
    value_d = value_q;
    put_d   = put_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          data0_d = in0;
          data1_d = in1;
          data2_d = in2;
          valid_d = in_valid;
          if (|in_valid) begin
            state_d = StSend;
            put_d   = 1'b1;
            value_d = pick_first(in_valid, in0, in1, in2);
          end else begin
            state_d = StFin;
          end
        end
      end
      StSend: begin
        if (take && put_q) begin
          // The slot on the bus is always the lowest set flag; clear just that bit.
          valid_d = valid_q & (valid_q - 3'd1);
          if (|valid_d) begin
            value_d = pick_first(valid_d, data0_q, data1_q, data2_q);
          end else begin
            state_d = StFin;
            put_d   = 1'b0;
            value_d = '0;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        put_d   = 1'b0;
        value_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      data0_q <= '0;
      data1_q <= '0;
      data2_q <= '0;
      valid_q <= '0;
      value_q <= '0;
      put_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      valid_q <= valid_d;
      value_q <= value_d;
      put_q   <= put_d;
    end
  end

  assign value_out = value_q;
  assign put_out   = put_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFin);

endmodule

// File: tb/tb_slot_dispenser.sv
// Bench for slot_dispenser: directed scenarios plus random traffic, all checked
// against a queue-based model of the bundle being dispensed.
module tb_slot_dispenser;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] in0, in1, in2;
  logic             in0_valid, in1_valid, in2_valid;
  logic             take;
  logic [WIDTH-1:0] value_out;
  logic             put_out;
  logic             busy;
  logic             done;

  slot_dispenser #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in0_valid (in0_valid),
    .in1_valid (in1_valid),
    .in2_valid (in2_valid),
    .take      (take),
    .value_out (value_out),
    .put_out   (put_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model: a bundle is held (m_busy); its undelivered values wait in m_q; m_fin marks
  // the single done cycle after the last value is taken (or after an empty load).
  logic             m_busy;
  logic             m_fin;
  logic [WIDTH-1:0] m_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (!reset) begin
      m_busy = 1'b0;
      m_fin  = 1'b0;
      m_q.delete();
    end else if (!m_busy) begin
      if (load) begin
        m_q.delete();
        if (in0_valid) m_q.push_back(in0);
        if (in1_valid) m_q.push_back(in1);
        if (in2_valid) m_q.push_back(in2);
        m_busy = 1'b1;
        m_fin  = (m_q.size() == 0);
      end
    end else if (m_fin) begin
      m_busy = 1'b0;
      m_fin  = 1'b0;
    end else if (take) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_fin = 1'b1;
    end
  endtask

  task automatic check_outputs();
    logic             e_put;
    logic [WIDTH-1:0] e_val;
    e_put = m_busy && !m_fin && (m_q.size() > 0);
    e_val = e_put ? m_q[0] : '0;
    check_eq("put_out", 32'(put_out), 32'(e_put));
    check_eq("value_out", 32'(value_out), 32'(e_val));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("done", 32'(done), 32'(m_fin));
  endtask

  // One clock: model follows the edge, outputs are compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_bundle(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] c, input logic [2:0] v);
    in0 = a; in1 = b; in2 = c;
    {in2_valid, in1_valid, in0_valid} = v;
  endtask

  initial begin
    m_busy = 1'b0;
    m_fin  = 1'b0;
    reset = 1'b0;
    load  = 1'b0;
    take  = 1'b0;
    set_bundle(8'h00, 8'h00, 8'h00, 3'b000);
    @(negedge clk);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Full bundle, take held high.
    take = 1'b1;
    set_bundle(8'h11, 8'h22, 8'h33, 3'b111);
    load = 1'b1;
    tick();
    load = 1'b0;
    check_eq("first_put", 32'(value_out), 32'h11);
    repeat (5) tick();

    // Same bundle with take stalled for 4 cycles.
    take = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (4) begin
      check_eq("stall_hold", 32'(value_out), 32'h11);
      tick();
    end
    take = 1'b1;
    repeat (5) tick();

    // Only slot 2 valid.
    set_bundle(8'h5A, 8'h6B, 8'hA5, 3'b100);
    load = 1'b1;
    tick();
    load = 1'b0;
    check_eq("slot2_only", 32'(value_out), 32'hA5);
    repeat (3) tick();

    // No slot valid: done at load+1.
    set_bundle(8'h01, 8'h02, 8'h03, 3'b000);
    load = 1'b1;
    tick();
    load = 1'b0;
    check_eq("empty_done", 32'(done), 32'd1);
    repeat (2) tick();

    // Second load while busy must be ignored.
    take = 1'b0;
    set_bundle(8'h11, 8'h22, 8'h33, 3'b111);
    load = 1'b1;
    tick();
    set_bundle(8'hDE, 8'hAD, 8'hBE, 3'b111);
    repeat (2) tick();
    load = 1'b0;
    take = 1'b1;
    repeat (5) tick();

    // Reset after the first handshake.
    set_bundle(8'h11, 8'h22, 8'h33, 3'b111);
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check_eq("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    repeat (2) tick();
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (5) tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      load  = ($urandom_range(0, 2) == 0);
      take  = ($urandom_range(0, 2) != 0);
      set_bundle(8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
